// File: rtl/fb_pkg.sv
// Shared types for the frame-buffer scanner: FSM states and the per-pixel tag
// that travels alongside each RAM read.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } scan_state_t;

  // Tag coordinate fields are sized for the largest supported raster.
  localparam int XY_MAX_W = 16;

  typedef struct packed {
    logic                valid;
    logic [XY_MAX_W-1:0] x;
    logic [XY_MAX_W-1:0] y;
    logic                first;
    logic                last;
  } scan_tag_t;

  localparam scan_tag_t TAG_IDLE = '0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/framebuffer_scanner_delay.sv
// RD_LAT-deep tag pipeline that keeps coordinates and markers aligned with
// returning RAM data.
module scan_delay_line
  import fb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  scan_tag_t din,
  output scan_tag_t dout,
  output logic      empty
);

  scan_tag_t stage [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= TAG_IDLE;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  // Empty means nothing is queued behind the output stage, so the line
  // drains completely on the next shift.
  always_comb begin
    empty = !din.valid;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      if (stage[i].valid) empty = 1'b0;
    end
  end

  assign dout = stage[RD_LAT-1];

endmodule

// File: rtl/framebuffer_scanner.sv
// Raster-order scan-out engine: issues pixel RAM reads for an H_RES x V_RES
// frame at a runtime base and re-aligns returned data with x/y and markers.
module framebuffer_scanner
  import fb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int H_RES  = 256,
  parameter int V_RES  = 256,
  parameter int RD_LAT = 1,
  localparam int XW    = idx_width(H_RES),
  localparam int YW    = idx_width(V_RES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              continuous,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] pixel,
  output logic              pixel_valid,
  output logic [XW-1:0]     x,
  output logic [YW-1:0]     y,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  scan_state_t       state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] off_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  scan_tag_t         iss_tag;
  scan_tag_t         tag_out;
  logic              dl_empty;

  logic              issue_go;
  logic [ADDR_W-1:0] cur_base;
  logic [ADDR_W-1:0] cur_off;
  logic [XW-1:0]     cur_x;
  logic [YW-1:0]     cur_y;
  logic              line_end;
  logic              frame_end;

  // A start seen in IDLE issues pixel (0,0) on the same edge, straight from
  // base_addr, so the frame begins without a dead cycle.
  always_comb begin
    issue_go = enable && ((state == IDLE && start) || state == SCAN);
    cur_base = base_q;
    cur_off  = off_q;
    cur_x    = x_q;
    cur_y    = y_q;
    if (state == IDLE) begin
      cur_base = base_addr;
      cur_off  = '0;
      cur_x    = '0;
      cur_y    = '0;
    end
    line_end  = (cur_x == X_LAST);
    frame_end = line_end && (cur_y == Y_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      base_q  <= '0;
      off_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      iss_tag <= TAG_IDLE;
    end else begin
      rd_en         <= issue_go;
      iss_tag.valid <= issue_go;
      iss_tag.x     <= XY_MAX_W'(cur_x);
      iss_tag.y     <= XY_MAX_W'(cur_y);
      iss_tag.first <= (cur_x == '0) && (cur_y == '0);
      iss_tag.last  <= frame_end;
      if (issue_go) rd_addr <= cur_base + cur_off;

      case (state)
        IDLE: begin
          if (start) begin
            state  <= SCAN;
            base_q <= base_addr;
            off_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
          end
        end
        SCAN: ;
        DRAIN: begin
          if (dl_empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (issue_go) begin
        if (frame_end) begin
          x_q   <= '0;
          y_q   <= '0;
          off_q <= '0;
          if (continuous) base_q <= base_addr;
          else            state  <= DRAIN;
        end else begin
          off_q <= cur_off + ADDR_W'(1);
          if (line_end) begin
            x_q <= '0;
            y_q <= cur_y + YW'(1);
          end else begin
            x_q <= cur_x + XW'(1);
          end
        end
      end
    end
  end

  scan_delay_line #(.RD_LAT(RD_LAT)) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (iss_tag),
    .dout  (tag_out),
    .empty (dl_empty)
  );

  assign pixel       = rd_data;
  assign pixel_valid = tag_out.valid;
  assign x           = tag_out.x[XW-1:0];
  assign y           = tag_out.y[YW-1:0];
  assign frame_start = tag_out.valid && tag_out.first;
  assign frame_done  = tag_out.valid && tag_out.last;
  assign busy        = (state != IDLE);

  if (XW < XY_MAX_W) begin : g_unused_x
    logic unused_x;
    assign unused_x = ^tag_out.x[XY_MAX_W-1:XW];
  end
  if (YW < XY_MAX_W) begin : g_unused_y
    logic unused_y;
    assign unused_y = ^tag_out.y[XY_MAX_W-1:YW];
  end

endmodule

// File: tb/tb_framebuffer_scanner.sv
// Directed bench for framebuffer_scanner: 4x2 frame, RD_LAT=2, RAM returns addr.
module tb_framebuffer_scanner;

  logic        clk = 1'b0;
  logic        reset, enable, start, continuous;
  logic [15:0] base_addr;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [31:0] rd_data;
  logic [31:0] pixel;
  logic        pixel_valid;
  logic [1:0]  x;
  logic [0:0]  y;
  logic        frame_start, frame_done, busy;

  framebuffer_scanner #(
    .ADDR_W(16), .DATA_W(32), .H_RES(4), .V_RES(2), .RD_LAT(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .continuous(continuous), .base_addr(base_addr), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .pixel(pixel),
    .pixel_valid(pixel_valid), .x(x), .y(y), .frame_start(frame_start),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Two-cycle RAM whose data equals its address.
  logic [15:0] ram_p1 = '0, ram_p2 = '0;
  always @(posedge clk) begin
    ram_p1 <= rd_addr;
    ram_p2 <= ram_p1;
  end
  assign rd_data = {16'h0000, ram_p2};

  typedef struct {
    logic [31:0] data;
    logic [1:0]  px;
    logic        py;
    logic        fs;
    logic        fd;
    int          cyc;
  } pix_t;

  logic [15:0] iss_addr[$];
  int          iss_cyc[$];
  pix_t        pix_q[$];
  int          fd_cyc[$];
  int          fs_cyc[$];
  int          cyc = 0;
  int          busy_fall = -1;
  logic        busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rd_en) begin
      iss_addr.push_back(rd_addr);
      iss_cyc.push_back(cyc);
    end
    if (pixel_valid) pix_q.push_back('{pixel, x, y[0], frame_start, frame_done, cyc});
    if (frame_done) fd_cyc.push_back(cyc);
    if (frame_start) fs_cyc.push_back(cyc);
    if (busy_prev && !busy && busy_fall < 0) busy_fall = cyc;
    busy_prev = busy;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_addr.delete();
    iss_cyc.delete();
    pix_q.delete();
    fd_cyc.delete();
    fs_cyc.delete();
    busy_fall = -1;
  endtask

  typedef struct {
    logic [15:0] base;
    int          stall_at;
    int          stall_len;
    int          restart_at;
    logic [15:0] exp_a0;
    logic [15:0] exp_a7;
    int          exp_gaps;
  } vec_t;

  task automatic run_vec(input vec_t v, input int k);
    clear_logs();
    base_addr = v.base;
    enable    = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 30; c++) begin
      enable = !(c >= v.stall_at && c < v.stall_at + v.stall_len);
      start  = (c == v.restart_at);
      if (c == v.restart_at) base_addr = 16'h0900;
      tick();
    end
    start  = 1'b0;
    enable = 1'b1;

    chk($sformatf("v%0d_issue_count", k), iss_addr.size(), 8);
    chk($sformatf("v%0d_pixel_count", k), pix_q.size(), 8);
    chk($sformatf("v%0d_frame_done_count", k), fd_cyc.size(), 1);
    if (iss_addr.size() == 8) begin
      for (int i = 0; i < 8; i++)
        chk($sformatf("v%0d_rd_addr%0d", k, i), iss_addr[i], 16'(v.base + i));
      chk($sformatf("v%0d_first_addr", k), iss_addr[0], v.exp_a0);
      chk($sformatf("v%0d_last_addr", k), iss_addr[7], v.exp_a7);
      chk($sformatf("v%0d_rd_en_gaps", k), iss_cyc[7] - iss_cyc[0] - 7, v.exp_gaps);
    end
    if (pix_q.size() == 8 && iss_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("v%0d_pixel%0d", k, i), pix_q[i].data, {16'h0000, 16'(v.base + i)});
        chk($sformatf("v%0d_xy%0d", k, i), {pix_q[i].px, pix_q[i].py}, {2'(i % 4), 1'(i / 4)});
        chk($sformatf("v%0d_marks%0d", k, i), {pix_q[i].fs, pix_q[i].fd}, {i == 0, i == 7});
        chk($sformatf("v%0d_latency%0d", k, i), pix_q[i].cyc, iss_cyc[i] + 2);
      end
      chk($sformatf("v%0d_valid_gaps", k), pix_q[7].cyc - pix_q[0].cyc - 7, v.exp_gaps);
    end
    if (fd_cyc.size() == 1)
      chk($sformatf("v%0d_busy_fall", k), busy_fall, fd_cyc[0] + 1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h0100, -1, 0, -1, 16'h0100, 16'h0107, 0};
    vecs[1] = '{16'h0100,  3, 2, -1, 16'h0100, 16'h0107, 2};
    vecs[2] = '{16'hFFFE, -1, 0, -1, 16'hFFFE, 16'h0005, 0};
    vecs[3] = '{16'h1234,  6, 1, -1, 16'h1234, 16'h123B, 1};
    vecs[4] = '{16'h0400, -1, 0,  3, 16'h0400, 16'h0407, 0};

    reset = 1'b1; enable = 1'b0; start = 1'b0; continuous = 1'b0; base_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_ctrl", {rd_en, pixel_valid, busy, frame_start, frame_done}, 5'b0);
    chk("reset_addr_xy", {rd_addr, x, y}, 19'h0);

    for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

    // Continuous: base switches to 0x8000 mid-frame, continuous drops in frame 2.
    clear_logs();
    continuous = 1'b1;
    base_addr  = 16'h0000;
    enable     = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if (iss_addr.size() >= 4)  base_addr  = 16'h8000;
      if (iss_addr.size() >= 10) continuous = 1'b0;
      tick();
    end
    chk("cont_issue_count", iss_addr.size(), 16);
    chk("cont_pixel_count", pix_q.size(), 16);
    chk("cont_marker_counts", {fs_cyc.size(), fd_cyc.size()}, {32'd2, 32'd2});
    if (iss_addr.size() == 16) begin
      for (int i = 0; i < 16; i++)
        chk($sformatf("cont_rd_addr%0d", i), iss_addr[i], (i < 8) ? 16'(i) : 16'(16'h8000 + i - 8));
      chk("cont_no_bubble", iss_cyc[15] - iss_cyc[0], 15);
    end
    if (fs_cyc.size() == 2 && fd_cyc.size() == 2)
      chk("cont_done_then_start", fs_cyc[1] - fd_cyc[0], 1);
    chk("cont_idle_after", busy, 1'b0);

    // Reset in the middle of a frame.
    clear_logs();
    base_addr = 16'h0200;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && iss_addr.size() < 5; c++) tick();
    chk("rstmid_reached_5_issues", iss_addr.size(), 5);
    reset = 1'b1;
    tick();
    chk("rstmid_ctrl", {rd_en, pixel_valid, busy, frame_start, frame_done}, 5'b0);
    chk("rstmid_addr_xy", {rd_addr, x, y}, 19'h0);
    reset = 1'b0;
    clear_logs();
    for (int c = 0; c < 5; c++) tick();
    chk("rstmid_no_stale_pixels", pix_q.size(), 0);
    chk("rstmid_no_issue", iss_addr.size(), 0);
    run_vec('{16'h0300, -1, 0, -1, 16'h0300, 16'h0307, 0}, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
